// File: rtl/snake_video_timing_pkg.sv
// Shared definitions for the GreedySnake raster timing generator: coordinate width,
// FSM encoding and the 1280x720 reference geometry.
package snake_video_timing_pkg;

    localparam int DEFAULT_CW = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vt_state_e;

    // 720p60 on a 74.25 MHz pixel clock: total / sync / back porch / active
    localparam int H_TOTAL_720P  = 1650;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BPORCH_720P = 220;
    localparam int H_RES_720P    = 1280;
    localparam int V_TOTAL_720P  = 750;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BPORCH_720P = 20;
    localparam int V_RES_720P    = 720;

endpackage

// File: rtl/snake_video_axis_counter.sv
// One raster axis: position counter with wrap plus sync / active / 1-based index decode.
// Used once for pixels within a line and once for lines within a frame.
module snake_video_axis_counter
    import snake_video_timing_pkg::*;
#(
    parameter int CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    input  logic [CW-1:0] total,
    input  logic [CW-1:0] sync,
    input  logic [CW-1:0] bporch,
    input  logic [CW-1:0] res,
    output logic          wrap,
    output logic          in_sync,
    output logic          in_act,
    output logic [CW-1:0] idx
);

    logic [CW-1:0] pos;
    logic [CW-1:0] act_start;
    logic [CW-1:0] act_end;

    // Layout is sync, back porch, active, front porch; sums never exceed total.
    assign act_start = sync + bporch;
    assign act_end   = act_start + res;

    assign wrap    = (pos == total - CW'(1));
    assign in_sync = (pos < sync);
    assign in_act  = (pos >= act_start) && (pos < act_end);
    assign idx     = in_act ? (pos - act_start + CW'(1)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (clr) begin
            pos <= '0;
        end else if (adv) begin
            pos <= wrap ? '0 : pos + CW'(1);
        end
    end

endmodule

// File: rtl/snake_video_timing.sv
// Programmable HS/VS/DE generator with 1-based active-area coordinates.
// All outputs come from one register stage after the position counters, so they stay aligned.
module snake_video_timing
    import snake_video_timing_pkg::*;
#(
    parameter int CW = DEFAULT_CW
) (
    input  logic          I_pxl_clk,
    input  logic          I_rst_n,
    input  logic          I_en,
    input  logic [CW-1:0] I_h_total,
    input  logic [CW-1:0] I_h_sync,
    input  logic [CW-1:0] I_h_bporch,
    input  logic [CW-1:0] I_h_res,
    input  logic [CW-1:0] I_v_total,
    input  logic [CW-1:0] I_v_sync,
    input  logic [CW-1:0] I_v_bporch,
    input  logic [CW-1:0] I_v_res,
    output logic [CW-1:0] O_h_cnt,
    output logic [CW-1:0] O_v_cnt,
    output logic          O_busy,
    output logic          O_de,
    output logic          O_hs,
    output logic          O_vs
);

    vt_state_e     state;
    logic          run;
    logic          frame_end;
    logic          h_wrap;
    logic          h_sync;
    logic          h_act;
    logic [CW-1:0] h_idx;
    logic          v_wrap;
    logic          v_sync;
    logic          v_act;
    logic [CW-1:0] v_idx;

    assign run       = (state == ST_RUN);
    assign frame_end = h_wrap && v_wrap;

    snake_video_axis_counter #(.CW(CW)) u_h_axis (
        .clk     (I_pxl_clk),
        .rst_n   (I_rst_n),
        .clr     (!run),
        .adv     (run),
        .total   (I_h_total),
        .sync    (I_h_sync),
        .bporch  (I_h_bporch),
        .res     (I_h_res),
        .wrap    (h_wrap),
        .in_sync (h_sync),
        .in_act  (h_act),
        .idx     (h_idx)
    );

    snake_video_axis_counter #(.CW(CW)) u_v_axis (
        .clk     (I_pxl_clk),
        .rst_n   (I_rst_n),
        .clr     (!run),
        .adv     (run && h_wrap),
        .total   (I_v_total),
        .sync    (I_v_sync),
        .bporch  (I_v_bporch),
        .res     (I_v_res),
        .wrap    (v_wrap),
        .in_sync (v_sync),
        .in_act  (v_act),
        .idx     (v_idx)
    );

    // A frame in progress always completes; I_en is only consulted at the frame boundary.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (I_en) state <= ST_RUN;
                ST_RUN:  if (frame_end && !I_en) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_busy  <= 1'b0;
            O_hs    <= 1'b0;
            O_vs    <= 1'b0;
            O_de    <= 1'b0;
            O_h_cnt <= '0;
            O_v_cnt <= '0;
        end else begin
            O_busy  <= run;
            O_hs    <= run && h_sync;
            O_vs    <= run && v_sync;
            O_de    <= run && h_act && v_act;
            O_h_cnt <= run ? h_idx : '0;
            O_v_cnt <= run ? v_idx : '0;
        end
    end

endmodule

// File: tb/tb_snake_video_timing.sv
// Directed bench for snake_video_timing: small 10x6 raster table, enable/reset sequences, 720p line checks.
module tb_snake_video_timing;

    localparam int CW = 12;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [CW-1:0] h_total, h_sync, h_bporch, h_res;
    logic [CW-1:0] v_total, v_sync, v_bporch, v_res;
    logic [CW-1:0] h_cnt, v_cnt;
    logic          busy, de, hs, vs;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int            idx;
        logic          busy;
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] hc;
        logic [CW-1:0] vc;
    } vec_t;

    vec_t tbl[13];

    snake_video_timing #(.CW(CW)) dut (
        .I_pxl_clk  (clk),
        .I_rst_n    (rst_n),
        .I_en       (en),
        .I_h_total  (h_total),
        .I_h_sync   (h_sync),
        .I_h_bporch (h_bporch),
        .I_h_res    (h_res),
        .I_v_total  (v_total),
        .I_v_sync   (v_sync),
        .I_v_bporch (v_bporch),
        .I_v_res    (v_res),
        .O_h_cnt    (h_cnt),
        .O_v_cnt    (v_cnt),
        .O_busy     (busy),
        .O_de       (de),
        .O_hs       (hs),
        .O_vs       (vs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " busy"}, int'(busy), 0);
        chk({name, " hs"}, int'(hs), 0);
        chk({name, " vs"}, int'(vs), 0);
        chk({name, " de"}, int'(de), 0);
        chk({name, " h_cnt"}, int'(h_cnt), 0);
        chk({name, " v_cnt"}, int'(v_cnt), 0);
    endtask

    task automatic set_small();
        h_total = 12'd10; h_sync = 12'd1; h_bporch = 12'd2; h_res = 12'd4;
        v_total = 12'd6;  v_sync = 12'd1; v_bporch = 12'd1; v_res = 12'd3;
    endtask

    task automatic set_720p();
        h_total = 12'd1650; h_sync = 12'd40; h_bporch = 12'd220; h_res = 12'd1280;
        v_total = 12'd750;  v_sync = 12'd5;  v_bporch = 12'd20;  v_res = 12'd720;
    endtask

    // Raise enable, let it be sampled, then return with outputs showing frame index 0.
    task automatic start_run();
        en = 1'b1;
        step();
        step();
    endtask

    task automatic chk_vec(input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", v.idx);
        chk({tag, " busy"}, int'(busy), int'(v.busy));
        chk({tag, " hs"}, int'(hs), int'(v.hs));
        chk({tag, " vs"}, int'(vs), int'(v.vs));
        chk({tag, " de"}, int'(de), int'(v.de));
        chk({tag, " h_cnt"}, int'(h_cnt), int'(v.hc));
        chk({tag, " v_cnt"}, int'(v_cnt), int'(v.vc));
    endtask

    initial begin
        int de_n, hs_n, vs_n, busy_n, idx;

        // Frame index k shows h_pos = k % 10, v_pos = k / 10 (small timing).
        tbl[0]  = '{0,   1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0};
        tbl[1]  = '{3,   1'b1, 1'b0, 1'b1, 1'b0, 12'd1, 12'd0};
        tbl[2]  = '{10,  1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[3]  = '{23,  1'b1, 1'b0, 1'b0, 1'b1, 12'd1, 12'd1};
        tbl[4]  = '{26,  1'b1, 1'b0, 1'b0, 1'b1, 12'd4, 12'd1};
        tbl[5]  = '{27,  1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd1};
        tbl[6]  = '{35,  1'b1, 1'b0, 1'b0, 1'b1, 12'd3, 12'd2};
        tbl[7]  = '{46,  1'b1, 1'b0, 1'b0, 1'b1, 12'd4, 12'd3};
        tbl[8]  = '{50,  1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[9]  = '{54,  1'b1, 1'b0, 1'b0, 1'b0, 12'd2, 12'd0};
        tbl[10] = '{59,  1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[11] = '{60,  1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0};
        tbl[12] = '{120, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};

        // Reset and idle
        rst_n = 1'b0;
        en    = 1'b0;
        set_small();
        step();
        step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();
        step();
        step();
        chk_idle("idle_en0");

        // Two frames with enable held, dropped mid second frame
        start_run();
        de_n = 0; hs_n = 0; vs_n = 0; busy_n = 0;
        for (int k = 0; k <= 122; k++) begin
            if (k > 0) step();
            if (k == 70) en = 1'b0;
            foreach (tbl[t]) if (tbl[t].idx == k) chk_vec(tbl[t]);
            if (k < 60) begin
                de_n += int'(de);
                hs_n += int'(hs);
                vs_n += int'(vs);
            end
            busy_n += int'(busy);
        end
        chk("frame de cycles", de_n, 12);
        chk("frame hs cycles", hs_n, 6);
        chk("frame vs cycles", vs_n, 10);
        chk("two frame busy cycles", busy_n, 120);
        chk_idle("after two frames");

        // One-cycle enable pulse runs exactly one frame
        en = 1'b1;
        step();
        en = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            busy_n += int'(busy);
        end
        chk("pulse busy cycles", busy_n, 60);
        chk_idle("after pulse");

        // Asynchronous reset in line 3, then restart
        start_run();
        for (int k = 0; k < 35; k++) step();
        chk("pre reset de", int'(de), 1);
        rst_n = 1'b0;
        #1;
        chk_idle("async reset");
        step();
        step();
        rst_n = 1'b1;
        start_run();
        chk("restart busy", int'(busy), 1);
        chk("restart hs", int'(hs), 1);
        chk("restart vs", int'(vs), 1);
        for (int k = 0; k < 23; k++) step();
        chk("restart first de", int'(de), 1);
        chk("restart first h_cnt", int'(h_cnt), 1);
        chk("restart first v_cnt", int'(v_cnt), 1);
        en = 1'b0;
        for (int k = 0; k < 60; k++) step();
        chk_idle("after restart frame");

        // 720p: first lines up to and through the first active line
        set_720p();
        start_run();
        hs_n = 0; de_n = 0;
        idx = 0;
        for (int k = 0; k <= 42791; k++) begin
            if (k > 0) step();
            idx = k;
            if (k < 1650) hs_n += int'(hs);
            if (k >= 41250) de_n += int'(de);
            if (k == 0) chk("720 hs at 0", int'(hs) + int'(vs), 2);
            if (k == 40) chk("720 hs end", int'(hs), 0);
            if (k == 1650) chk("720 hs period", int'(hs), 1);
            if (k == 8250) chk("720 vs end", int'(vs), 0);
            if (k == 41509) chk("720 de before corner", int'(de), 0);
            if (k == 41510) begin
                chk("720 corner de", int'(de), 1);
                chk("720 corner h_cnt", int'(h_cnt), 1);
                chk("720 corner v_cnt", int'(v_cnt), 1);
            end
            if (k == 42789) begin
                chk("720 last px de", int'(de), 1);
                chk("720 last px h_cnt", int'(h_cnt), 1280);
            end
            if (k == 42790) chk("720 front porch de", int'(de), 0);
        end
        chk("720 hs width", hs_n, 40);
        chk("720 de per line", de_n, 1280);
        chk("720 loop end", idx, 42791);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/snake_video_timing.md
Name: snake_video_timing

Overview:
Programmable raster video timing generator for the GreedySnake HDMI path, e.g. 1280x720 @ 1650x750 totals.
- Produces HS, VS and DE from run-time timing inputs.
- Exports 1-based active-area pixel and line coordinates.
- The snake renderer uses these coordinates to pick pixel colours.
- Runs frames while enabled and reports activity on a busy flag.

Parameters:
CW, 12, width of all timing inputs and coordinate outputs

Ports:
I_pxl_clk  in  1  pixel clock; all logic on rising edge
I_rst_n  in  1  asynchronous active-low reset
I_en  in  1  run enable, level sensitive
I_h_total  in  CW  pixels per line, including blanking
I_h_sync  in  CW  HS pulse width in pixels
I_h_bporch  in  CW  horizontal back porch in pixels
I_h_res  in  CW  active pixels per line
I_v_total  in  CW  lines per frame
I_v_sync  in  CW  VS pulse width in lines
I_v_bporch  in  CW  vertical back porch in lines
I_v_res  in  CW  active lines per frame
O_h_cnt  out  CW  active pixel index 1..I_h_res; 0 outside the horizontal active region
O_v_cnt  out  CW  active line index 1..I_v_res, held for the whole line; 0 on vertical blanking lines
O_busy  out  1  high while frames are being generated
O_de  out  1  data enable
O_hs  out  1  horizontal sync, active high
O_vs  out  1  vertical sync, active high

Behaviour:
- Internal position counters: h_pos runs 0..I_h_total-1; v_pos runs 0..I_v_total-1.
  - h_pos wraps to 0 at I_h_total-1; v_pos advances on that h_pos wrap.
  - v_pos wraps at I_v_total-1.
- Line layout: sync, then back porch, then active, then front porch. Front porch = total - sync - bporch - res. The frame uses the same layout vertically.
- States:
  - IDLE: counters at 0, O_busy=0, O_hs=O_vs=O_de=0, O_h_cnt=O_v_cnt=0.
  - RUN.
- IDLE -> RUN when I_en=1 is sampled; the first RUN cycle has h_pos=0, v_pos=0.
- At the end of a frame (h_pos=I_h_total-1 and v_pos=I_v_total-1):
  - If I_en=1, the next frame starts seamlessly at 0,0.
  - Otherwise return to IDLE.
- I_en falling mid-frame does not abort; the frame always completes.
- O_busy=1 throughout RUN.
- All outputs are registered and mutually aligned, with no relative skew. They reflect the current h_pos/v_pos, with one register stage from the counters.
- Output decode:
  - O_hs = h_pos < I_h_sync.
  - O_vs = v_pos < I_v_sync.
  - h_act = h_pos in [I_h_sync+I_h_bporch, I_h_sync+I_h_bporch+I_h_res); v_act is defined the same way for v_pos.
  - O_de = h_act and v_act.
  - O_h_cnt = h_pos - (I_h_sync+I_h_bporch) + 1 when h_act, else 0. This is independent of v_act.
  - O_v_cnt = v_pos - (I_v_sync+I_v_bporch) + 1 when v_act, else 0.
- Timing inputs are sampled continuously but must be held stable while busy; changing them mid-frame gives undefined geometry and is not checked.
- Comparisons are unsigned at CW bits. Sums never exceed the total, so no overflow handling is required.
- Reset (asynchronous, any time, including mid-frame): go to IDLE with all outputs 0 immediately. RUN resumes on the first clock after release on which I_en=1.

Decomposition:
- Shared package: CW, state encoding (IDLE, RUN), the 720p default timing constants (1650/40/220/1280, 750/5/20/720).
- One natural sub-module: snake_video_axis_counter, instantiated twice (H and V). It holds the position counter with wrap, plus the sync, active and index decode, and takes total/sync/bporch/res as inputs.

Test Plan:
- Small timing (h: 10/1/2/4, v: 6/1/1/3), I_en=1 -> frame is 60 cycles.
  - O_hs high 1 of every 10 cycles; O_vs high for the first 10 cycles.
  - O_de high 4 cycles per line on lines 2..4 only; 12 DE cycles per frame.
- Same timing, coordinates -> during DE, O_h_cnt steps 1,2,3,4 and O_v_cnt is 1,2,3 per active line.
  - O_h_cnt is 0 outside h_act; O_v_cnt is 0 on blanking lines.
  - The last DE pixel shows O_h_cnt=4, O_v_cnt=3.
- I_en pulse of 1 cycle, then low -> O_busy high for exactly 60 cycles, then IDLE with all outputs 0.
- I_en held high -> back-to-back frames; the cycle after the last frame cycle has h_pos=v_pos=0 (O_hs=O_vs=1) with no idle gap.
- Reset asserted mid-frame (e.g. line 3) -> all outputs 0 asynchronously. After release with I_en=1, a fresh frame starts at 0,0.
- 720p settings -> HS period 1650, VS period 1,237,500 cycles, DE 1280 per line.
  - Corner pixels (1,1) and (1280,720) are coincident with O_de=1.
